vga_plot_arbiter: RTL and testbench
===================================

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter: X_W, 8, pixel X coordinate width.
REQ-002 Parameter: Y_W, 7, pixel Y coordinate width.
REQ-003 Parameter: C_W, 3, colour width.
REQ-004 Parameter: MAX_BURST, 16, maximum pixels accepted per grant before forced release.
REQ-005 Port: CLOCK_50  in  1  sole clock; one clock; all logic on rising edge.
REQ-006 Port: Reset  in  1  synchronous, active-high reset.
REQ-007 Port: Req  in  3  per-requester pixel-valid; bit0 erase, bit1 character draw, bit2 HUD/timer.
REQ-008 Port: Last  in  3  per-requester last-pixel-of-burst flag, qualified by Req.
REQ-009 Port: XIn  in  3*X_W  packed X per requester, slice i = requester i.
REQ-010 Port: YIn  in  3*Y_W  packed Y per requester.
REQ-011 Port: ColorIn  in  3*C_W  packed colour per requester.
REQ-012 Port: Ack  out  3  one-hot, high in the cycle requester i's pixel is accepted.
REQ-013 Port: Grant  out  3  one-hot or zero, current bus owner.
REQ-014 Port: Plot  out  1  pixel write strobe to VGA adapter.
REQ-015 Port: XOut / YOut / Color  out  X_W / Y_W / C_W  registered pixel to VGA adapter.
REQ-016 Port: Busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE and OWNED.
REQ-018 IDLE: Grant=0; if any Req bit set, the winner SHALL be registered into Grant and state SHALL become OWNED on the next edge.
REQ-019 Arbitration SHALL be fixed priority, bit0 highest, except the previously released owner SHALL lose to any other pending requester.
REQ-020 With no other requester pending, the previously released owner SHALL be granted again.
REQ-021 OWNED: Ack[i] SHALL equal Grant[i] & Req[i], combinationally; a pixel is accepted on the edge where Ack is high.
REQ-022 On acceptance, XOut/YOut/Color SHALL load the owner's slice and Plot SHALL be 1 the following cycle (latency 1); otherwise Plot SHALL be 0 and XOut/YOut/Color SHALL hold.
REQ-023 A burst counter SHALL count accepted pixels per grant, cleared on each new grant, width clog2(MAX_BURST+1).
REQ-024 Release (Grant->0, state->IDLE next edge) SHALL occur on acceptance with Last[owner]=1, on the MAX_BURST-th acceptance, or on any OWNED cycle where Req[owner]=0.
REQ-025 Minimum gap between two bursts SHALL be one IDLE cycle (Grant=0 for exactly one cycle when requests are pending).
REQ-026 Non-owner Req, Last, XIn, YIn, ColorIn SHALL be ignored; non-owner Ack SHALL be 0.
REQ-027 Last asserted without Req SHALL have no effect.
REQ-028 Simultaneous Last and MAX_BURST on the same acceptance SHALL cause a single release.
REQ-029 Requester count-of-three and packing order SHALL be fixed; no other requester encoding is supported.

Reset
REQ-030 Reset SHALL force state IDLE, Grant=0, Ack=0, Plot=0, XOut=0, YOut=0, Color=0, Busy=0, burst counter=0, previous-owner record=none.
REQ-031 Reset asserted mid-burst SHALL abort the burst; no Plot SHALL be issued in the cycle after Reset.
REQ-032 The first arbitration after Reset SHALL be pure fixed priority.

Structure
REQ-033 A shared package vga_plot_pkg SHALL hold X_W/Y_W/C_W defaults, NUM_REQ=3, requester index constants (REQ_ERASE=0, REQ_DRAW=1, REQ_HUD=2), and the state enum.
REQ-034 Arbitration logic SHALL be one sub-module, plot_priority_pick (Req, mask of previous owner -> one-hot winner), combinational.

Verification
REQ-035 Reset, Req=3'b111 all Last=0 -> Grant=001 after 1 cycle, Ack[0] each cycle, Plot lags Ack by 1, release after 16 pixels, then Grant=010.
REQ-036 Erase sends 4 pixels (X=10..13,Y=5,Color=0) with Last on 4th while draw pending -> Plot 4 cycles with those values, 1 idle cycle, Grant=010.
REQ-037 Draw owner drops Req mid-burst after 3 pixels -> Grant=0 next edge, no further Ack[1], Plot count=3.
REQ-038 Only HUD requests, single pixel Last=1 repeatedly -> Grant=100 re-granted every 2 cycles, Ack[2] pulses every other cycle.
REQ-039 Reset asserted during erase burst pixel 2 -> Plot=0, Grant=0, XOut=0 next cycle; post-reset grant goes to bit0 if pending.
REQ-040 Non-owner changes XIn slice while HUD owns -> XOut unaffected, Ack for that requester stays 0.

Source files
------------

// File: rtl/vga_plot_pkg.sv
// Shared constants and types for the VGA pixel-plot arbiter.
package vga_plot_pkg;
  localparam int X_W_DEF   = 8;
  localparam int Y_W_DEF   = 7;
  localparam int C_W_DEF   = 3;
  localparam int NUM_REQ   = 3;
  localparam int REQ_ERASE = 0;
  localparam int REQ_DRAW  = 1;
  localparam int REQ_HUD   = 2;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;
endpackage

// File: rtl/plot_priority_pick.sv
// Fixed-priority pick (bit0 highest) that defers the masked requester
// whenever anyone else is pending.
module plot_priority_pick
  import vga_plot_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  output logic [NUM_REQ-1:0] o_win
);
  logic [NUM_REQ-1:0] w_pref;
  logic [NUM_REQ-1:0] w_pool;

  assign w_pref = i_req & ~i_mask;
  assign w_pool = (|w_pref) ? w_pref : i_req;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    o_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pool[i]) begin
        o_win    = '0;
        o_win[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Three-requester burst arbiter in front of the VGA adapter's single
// pixel-write port; one registered pixel per accepted request.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int C_W       = C_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic [2:0]         Req,
  input  logic [2:0]         Last,
  input  logic [3*X_W-1:0]   XIn,
  input  logic [3*Y_W-1:0]   YIn,
  input  logic [3*C_W-1:0]   ColorIn,
  output logic [2:0]         Ack,
  output logic [2:0]         Grant,
  output logic               Plot,
  output logic [X_W-1:0]     XOut,
  output logic [Y_W-1:0]     YOut,
  output logic [C_W-1:0]     Color,
  output logic               Busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t           r_state;
  logic [2:0]       r_grant;
  logic [2:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_plot;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [C_W-1:0]   r_c;

  logic [2:0]       w_win;
  logic [2:0]       w_ack;
  logic             w_accept;
  logic             w_last;
  logic             w_full;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic [C_W-1:0]   w_c;

  plot_priority_pick u_pick (
    .i_req  (Req),
    .i_mask (r_prev),
    .o_win  (w_win)
  );

  assign w_ack     = (r_state == ST_OWNED) ? (r_grant & Req) : 3'b000;
  assign w_accept  = |w_ack;
  assign w_last    = |(w_ack & Last);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_full    = (w_cnt_nxt == CNT_W'(MAX_BURST));

  // Grant is one-hot, so OR-ing the selected slices yields the owner's pixel.
  always_comb begin
    w_x = '0;
    w_y = '0;
    w_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_x = w_x | XIn[i*X_W +: X_W];
        w_y = w_y | YIn[i*Y_W +: Y_W];
        w_c = w_c | ColorIn[i*C_W +: C_W];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_plot  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
    end else begin
      r_plot <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|Req) begin
            r_grant <= w_win;
            r_cnt   <= '0;
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_accept) begin
            r_plot <= 1'b1;
            r_x    <= w_x;
            r_y    <= w_y;
            r_c    <= w_c;
            r_cnt  <= w_cnt_nxt;
          end
          // Owner dropping Req releases just like a completed burst.
          if (!w_accept || w_last || w_full) begin
            r_grant <= '0;
            r_prev  <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Ack   = w_ack;
  assign Grant = r_grant;
  assign Plot  = r_plot;
  assign XOut  = r_x;
  assign YOut  = r_y;
  assign Color = r_c;
  assign Busy  = (r_state == ST_OWNED);
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus a
// randomized run checked against a behavioural owner/burst model.
module tb_vga_plot_arbiter;
  logic        CLOCK_50 = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  Req = '0, Last = '0;
  logic [23:0] XIn = '0;
  logic [20:0] YIn = '0;
  logic [8:0]  ColorIn = '0;
  logic [2:0]  Ack, Grant;
  logic        Plot, Busy;
  logic [7:0]  XOut;
  logic [6:0]  YOut;
  logic [2:0]  Color;

  int n_chk = 0, n_fail = 0;

  // Model: owner index (-1 = nobody), last released owner, pixels this burst.
  int m_owner = -1, m_prev = -1, m_cnt = 0;
  logic m_plot = 0;
  logic [7:0] m_x = 0;
  logic [6:0] m_y = 0;
  logic [2:0] m_c = 0;

  vga_plot_arbiter dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .Req(Req), .Last(Last),
    .XIn(XIn), .YIn(YIn), .ColorIn(ColorIn), .Ack(Ack), .Grant(Grant),
    .Plot(Plot), .XOut(XOut), .YOut(YOut), .Color(Color), .Busy(Busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [2:0] exp_grant();
    logic [2:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    if (Reset) begin
      m_owner = -1; m_prev = -1; m_cnt = 0; m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
    end else if (m_owner < 0) begin
      m_plot = 0;
      if (Req != 0) begin
        for (int i = 2; i >= 0; i--) if (Req[i] && i != m_prev) m_owner = i;
        if (m_owner < 0) for (int i = 2; i >= 0; i--) if (Req[i]) m_owner = i;
        m_cnt = 0;
      end
    end else if (Req[m_owner]) begin
      m_plot = 1;
      m_x = XIn[m_owner*8 +: 8]; m_y = YIn[m_owner*7 +: 7]; m_c = ColorIn[m_owner*3 +: 3];
      m_cnt++;
      if (Last[m_owner] || m_cnt == 16) begin m_prev = m_owner; m_owner = -1; end
    end else begin
      m_plot = 0; m_prev = m_owner; m_owner = -1;
    end
  endtask

  // Inputs change at negedge; the model samples them at the posedge.
  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    Reset = 1; Req = '0; Last = '0;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (Grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got %b exp 000", Grant); end
    n_chk++; if ({Plot, Busy, Ack} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl got plot=%b busy=%b ack=%b exp 0", Plot, Busy, Ack); end
    n_chk++; if ({XOut, YOut, Color} !== 18'b0) begin n_fail++; $display("FAIL reset_pix got %h/%h/%h exp 0", XOut, YOut, Color); end
  endtask

  task automatic test_max_burst();
    do_reset();
    Req = 3'b111; Last = '0;
    tick(); #1;
    n_chk++; if (Grant !== 3'b001) begin n_fail++; $display("FAIL mb_grant got %b exp 001", Grant); end
    for (int k = 0; k < 16; k++) begin
      XIn[7:0] = 8'(k);
      #1;
      n_chk++; if (Ack !== 3'b001) begin n_fail++; $display("FAIL mb_ack k=%0d got %b exp 001", k, Ack); end
      n_chk++; if (Plot !== (k > 0)) begin n_fail++; $display("FAIL mb_plot k=%0d got %b exp %b", k, Plot, k > 0); end
      tick();
    end
    #1;
    n_chk++; if ({Grant, Plot, XOut} !== {3'b000, 1'b1, 8'd15}) begin n_fail++; $display("FAIL mb_release got g=%b p=%b x=%0d exp g=000 p=1 x=15", Grant, Plot, XOut); end
    tick(); #1;
    n_chk++; if (Grant !== 3'b010) begin n_fail++; $display("FAIL mb_next got %b exp 010", Grant); end
  endtask

  task automatic test_erase_burst();
    do_reset();
    Req = 3'b011; Last = '0; YIn = '0; ColorIn = '0; XIn = '0;
    XIn[15:8] = 8'd200; YIn[6:0] = 7'd5;
    tick();
    for (int k = 0; k < 4; k++) begin
      XIn[7:0] = 8'(10 + k); Last[0] = (k == 3);
      #1;
      n_chk++; if (Ack !== 3'b001) begin n_fail++; $display("FAIL eb_ack k=%0d got %b exp 001", k, Ack); end
      tick(); #1;
      n_chk++; if ({Plot, XOut, YOut, Color} !== {1'b1, 8'(10 + k), 7'd5, 3'd0})
        begin n_fail++; $display("FAIL eb_pix k=%0d got p=%b x=%0d y=%0d c=%0d exp p=1 x=%0d y=5 c=0", k, Plot, XOut, YOut, Color, 10 + k); end
    end
    n_chk++; if ({Grant, Busy} !== 4'b0000) begin n_fail++; $display("FAIL eb_idle got g=%b busy=%b exp 000/0", Grant, Busy); end
    Req = 3'b010; Last = '0;
    tick(); #1;
    n_chk++; if ({Grant, Plot} !== 4'b0100) begin n_fail++; $display("FAIL eb_draw got g=%b p=%b exp 010/0", Grant, Plot); end
  endtask

  task automatic test_drop();
    int plots;
    plots = 0;
    do_reset();
    Req = 3'b010; Last = '0;
    tick();
    for (int k = 0; k < 3; k++) begin tick(); plots += Plot; end
    Req = 3'b000; #1;
    n_chk++; if (Ack !== 3'b000) begin n_fail++; $display("FAIL drop_ack got %b exp 000", Ack); end
    tick(); #1;
    n_chk++; if ({Grant, Plot} !== 4'b0000) begin n_fail++; $display("FAIL drop_rel got g=%b p=%b exp 000/0", Grant, Plot); end
    for (int k = 0; k < 3; k++) begin tick(); plots += Plot; end
    n_chk++; if (plots !== 3) begin n_fail++; $display("FAIL drop_count got %0d exp 3", plots); end
  endtask

  task automatic test_hud_repeat();
    do_reset();
    Req = 3'b100; Last = 3'b100;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_chk++; if (Ack[2] !== k[0]) begin n_fail++; $display("FAIL hud_ack k=%0d got %b exp %b", k, Ack[2], k[0]); end
      tick();
      n_chk++; if (Grant !== (k[0] ? 3'b000 : 3'b100)) begin n_fail++; $display("FAIL hud_grant k=%0d got %b", k, Grant); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Req = 3'b011; Last = '0; XIn[7:0] = 8'd33;
    tick(); tick();
    XIn[7:0] = 8'd34; Reset = 1;
    tick(); #1;
    n_chk++; if ({Plot, Grant, XOut} !== 12'b0) begin n_fail++; $display("FAIL rm_abort got p=%b g=%b x=%0d exp 0", Plot, Grant, XOut); end
    Reset = 0;
    tick(); #1;
    n_chk++; if (Grant !== 3'b001) begin n_fail++; $display("FAIL rm_regrant got %b exp 001", Grant); end
  endtask

  task automatic test_nonowner();
    do_reset();
    Req = 3'b100; Last = '0; XIn[23:16] = 8'd77;
    tick();
    Req = 3'b111; Last = 3'b011;
    for (int k = 0; k < 4; k++) begin
      XIn[15:0] = 16'($urandom); #1;
      n_chk++; if (Ack[1:0] !== 2'b00) begin n_fail++; $display("FAIL no_ack k=%0d got %b exp 00", k, Ack[1:0]); end
      tick(); #1;
      n_chk++; if (XOut !== 8'd77) begin n_fail++; $display("FAIL no_xout k=%0d got %0d exp 77", k, XOut); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      Reset = ($urandom_range(0, 59) == 0);
      Req = 3'($urandom); Last = 3'($urandom) & 3'($urandom);
      XIn = 24'($urandom); YIn = 21'($urandom); ColorIn = 9'($urandom);
      #1;
      n_chk++;
      if (Grant !== exp_grant() || Ack !== (exp_grant() & Req) || Busy !== (m_owner >= 0) ||
          Plot !== m_plot || XOut !== m_x || YOut !== m_y || Color !== m_c) begin
        n_fail++;
        $display("FAIL rnd k=%0d got g=%b a=%b b=%b p=%b x=%h y=%h c=%h exp g=%b a=%b b=%b p=%b x=%h y=%h c=%h",
                 k, Grant, Ack, Busy, Plot, XOut, YOut, Color,
                 exp_grant(), exp_grant() & Req, m_owner >= 0, m_plot, m_x, m_y, m_c);
      end
      tick();
    end
    Reset = 0;
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_max_burst();
    test_erase_burst();
    test_drop();
    test_hud_repeat();
    test_reset_mid();
    test_nonowner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
